// File: rtl/strobe_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// strobe_arbiter_pkg
// Shared definitions for the strobe arbiter and its round-robin picker:
//   - state_t     : FSM state encoding (IDLE / ISSUE / HOLD)
//   - clog2()     : constant ceil(log2(n)) used for index and counter widths
//   - params_ok() : legality check for NREQ / GAP, evaluated at elaboration
// No ports (package).
// ---------------------------------------------------------------------------
package strobe_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // At least two requesters, and at least two cycles between strobes so the
    // destination toggle synchroniser always sees a settled level.
    function automatic bit params_ok(input int nreq, input int gap);
        return (nreq >= 2) && (gap >= 2);
    endfunction

endpackage

// File: rtl/strobe_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting one position after
// 'last', wrapping, and returns the first set bit.
// Ports:
//   req   [NREQ] in  : request vector
//   last  [IDW]  in  : index granted most recently
//   valid        out : any request present
//   idx   [IDW]  out : chosen index (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick
    import strobe_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    // Candidate gi is the requester at distance gi+1 from 'last'.
    logic [IDW-1:0]  w_cand [NREQ];
    logic [NREQ-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign w_cand[gi] = IDW'((int'(last) + gi + 1) % NREQ);
            assign w_hit[gi]  = req[w_cand[gi]];
        end
    endgenerate

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/strobe_arbiter.sv
// ---------------------------------------------------------------------------
// strobe_arbiter
// Shares one strobe clock-crossing channel between NREQ requesters. Picks a
// requester round-robin, issues a one-cycle strobe with registered
// {src index, payload}, then holds off so consecutive strobes are at least
// GAP cycles apart.
// Ports:
//   clk          in  : clock
//   reset_n      in  : synchronous active-low reset
//   enable       in  : allows new arbitration (sampled in IDLE only)
//   req      [NREQ]  in  : request levels, held with stable data until ack
//   req_data [NREQ*WIDTH] in : payload i at [i*WIDTH +: WIDTH]
//   ack      [NREQ]  out : one-hot, one-cycle grant pulse
//   strobe_out       out : one-cycle pulse to the crossing
//   data_out [IDW+WIDTH] out : {src index, payload}, held until next issue
//   busy             out : high in ISSUE and HOLD
// ---------------------------------------------------------------------------
module strobe_arbiter
    import strobe_arbiter_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int GAP   = 4,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic                  strobe_out,
    output logic [IDW+WIDTH-1:0]  data_out,
    output logic                  busy
);

    localparam int CW = clog2(GAP);

    generate
        if (!params_ok(NREQ, GAP)) begin : g_param_check
            $error("strobe_arbiter: requires NREQ >= 2 and GAP >= 2");
        end
    endgenerate

    state_t               r_state, w_state_next;
    logic [CW-1:0]        r_hold_cnt, w_hold_next;
    logic [IDW-1:0]       r_last_grant, w_last_next;
    logic                 r_arm;
    logic                 w_arb;
    logic                 w_pick_valid;
    logic [IDW-1:0]       w_pick_idx;

    logic                 r_strobe, w_strobe_next;
    logic                 r_busy, w_busy_next;
    logic [NREQ-1:0]      r_ack, w_ack_next;
    logic [IDW+WIDTH-1:0] r_data_out, w_data_next;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req),
        .last  (r_last_grant),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // State register plus all registered outputs.
    // r_arm blocks arbitration in the first cycle after reset release, so a
    // reset that abandons a holdoff still leaves two cycles before the next
    // strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_arm        <= 1'b0;
            r_strobe     <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= '0;
            r_data_out   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_hold_cnt   <= w_hold_next;
            r_last_grant <= w_last_next;
            r_arm        <= 1'b1;
            r_strobe     <= w_strobe_next;
            r_busy       <= w_busy_next;
            r_ack        <= w_ack_next;
            r_data_out   <= w_data_next;
        end
    end

    // Next-state logic. HOLD lasts GAP-2 cycles: together with the ISSUE
    // cycle and the IDLE arbitration cycle that gives exactly GAP cycles
    // between strobes under continuous requests.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_arb        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_arm && enable && w_pick_valid) begin
                    w_state_next = ST_ISSUE;
                    w_arb        = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (GAP > 2) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = CW'(GAP - 2);
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_hold_next = r_hold_cnt - CW'(1);
                if (r_hold_cnt <= CW'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic, decoded from the next state so every output is a flop.
    // The grant (index, payload) is captured at the arbitration edge only.
    always_comb begin
        w_strobe_next = (w_state_next == ST_ISSUE);
        w_busy_next   = (w_state_next != ST_IDLE);
        w_ack_next    = '0;
        w_data_next   = r_data_out;
        w_last_next   = r_last_grant;
        if (w_arb) begin
            w_ack_next[w_pick_idx] = 1'b1;
            w_data_next = {w_pick_idx, req_data[int'(w_pick_idx) * WIDTH +: WIDTH]};
            w_last_next = w_pick_idx;
        end
    end

    assign strobe_out = r_strobe;
    assign busy       = r_busy;
    assign ack        = r_ack;
    assign data_out   = r_data_out;

endmodule

// File: tb/tb_strobe_arbiter.sv
// ---------------------------------------------------------------------------
// tb_strobe_arbiter
// Directed bench for strobe_arbiter (NREQ=4, WIDTH=8, GAP=4). Inputs are
// driven and outputs sampled on the falling clock edge. A toggle-based
// crossing into a 3x slower clk_out counts strobes on the far side.
// ---------------------------------------------------------------------------
module tb_strobe_arbiter;

    logic        clk     = 1'b0;
    logic        clk_out = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        strobe_out;
    logic [9:0]  data_out;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] exp_data [4];

    strobe_arbiter #(
        .NREQ  (4),
        .WIDTH (8),
        .GAP   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .strobe_out (strobe_out),
        .data_out   (data_out),
        .busy       (busy)
    );

    always #5  clk     = ~clk;
    always #15 clk_out = ~clk_out;

    // Toggle crossing: source toggles per strobe, destination counts edges
    // after a two-flop synchroniser.
    logic tgl = 1'b0;
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   n_tx = 0;
    int   n_rx = 0;

    always @(posedge clk) begin
        if (strobe_out) begin
            tgl  <= ~tgl;
            n_tx <= n_tx + 1;
        end
    end

    always @(posedge clk_out) begin
        s1 <= tgl;
        s2 <= s1;
        s3 <= s2;
        if (s2 ^ s3) n_rx <= n_rx + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance until strobe_out is seen or the budget runs out; n = cycles.
    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!strobe_out && n < budget);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx;
        int cnt;
        int s3_order [5];
        int s4_order [4];
        s3_order = '{1, 2, 3, 0, 1};
        s4_order = '{3, 0, 3, 0};
        exp_data = '{10'h011, 10'h122, 10'h233, 10'h344};

        // 1. Reset held three cycles with all requests high.
        reset_n  = 1'b0;
        enable   = 1'b1;
        req      = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_strobe", 32'(strobe_out), 32'd0);
            check("rst_ack",    32'(ack),        32'd0);
            check("rst_data",   32'(data_out),   32'd0);
        end
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        check("post_rst_guard", 32'(strobe_out), 32'd0);
        tick();
        check("first_strobe", 32'(strobe_out), 32'd1);
        check("first_ack",    32'(ack),        32'h1);
        check("first_data",   32'(data_out),   32'h011);

        // 3. Continuous requests: order 1,2,3,0,1, spacing exactly GAP.
        for (int k = 0; k < 5; k++) begin
            idx = s3_order[k];
            wait_strobe(10, n);
            check("rr_strobe",  32'(strobe_out), 32'd1);
            check("rr_spacing", 32'(n),          32'd4);
            check("rr_ack",     32'(ack),        32'(1 << idx));
            check("rr_data",    32'(data_out),   32'(exp_data[idx]));
        end
        req = 4'b0000;
        drain();

        // 2. Single requester 2 with payload A5; busy for three cycles.
        req_data[2*8 +: 8] = 8'hA5;
        req = 4'b0100;
        tick();
        check("s2_strobe", 32'(strobe_out), 32'd1);
        check("s2_ack",    32'(ack),        32'h4);
        check("s2_data",   32'(data_out),   32'h2A5);
        check("s2_busy0",  32'(busy),       32'd1);
        req = 4'b0000;
        tick();
        check("s2_busy1",   32'(busy),       32'd1);
        check("s2_nostrb",  32'(strobe_out), 32'd0);
        check("s2_noack",   32'(ack),        32'd0);
        check("s2_hold_dt", 32'(data_out),   32'h2A5);
        tick();
        check("s2_busy2", 32'(busy), 32'd1);
        tick();
        check("s2_busy3", 32'(busy), 32'd0);

        // 4. Requesters 0 and 3 continuous: alternating 3,0,3,0.
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            idx = s4_order[k];
            wait_strobe(10, n);
            check("alt_strobe",  32'(strobe_out), 32'd1);
            check("alt_spacing", 32'(n),          (k == 0) ? 32'd1 : 32'd4);
            check("alt_ack",     32'(ack),        32'(1 << idx));
            check("alt_data",    32'(data_out),   32'(exp_data[idx]));
        end
        req = 4'b0000;
        drain();

        // 5. enable low blocks arbitration; dropping it in HOLD has no effect.
        enable = 1'b0;
        req    = 4'b0010;
        cnt    = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (strobe_out || busy) cnt++;
        end
        check("en_blocked", 32'(cnt), 32'd0);
        enable = 1'b1;
        tick();
        check("en_strobe", 32'(strobe_out), 32'd1);
        check("en_ack",    32'(ack),        32'h2);
        check("en_data",   32'(data_out),   32'h122);
        req    = 4'b0000;
        enable = 1'b0;
        tick();
        check("en_hold1", 32'(busy), 32'd1);
        tick();
        check("en_hold2", 32'(busy), 32'd1);
        tick();
        check("en_hold3", 32'(busy), 32'd0);

        // 6. Reset during HOLD with requester 3 still pending.
        enable = 1'b1;
        req    = 4'b1000;
        tick();
        check("r6_strobe", 32'(strobe_out), 32'd1);
        check("r6_ack",    32'(ack),        32'h8);
        check("r6_data",   32'(data_out),   32'h344);
        tick();
        check("r6_in_hold", 32'(busy), 32'd1);
        reset_n = 1'b0;
        req     = 4'b1010;
        tick();
        check("r6_rst_strobe", 32'(strobe_out), 32'd0);
        check("r6_rst_ack",    32'(ack),        32'd0);
        check("r6_rst_busy",   32'(busy),       32'd0);
        check("r6_rst_data",   32'(data_out),   32'd0);
        reset_n = 1'b1;
        tick();
        check("r6_guard", 32'(strobe_out), 32'd0);
        tick();
        check("r6_wrap_strobe", 32'(strobe_out), 32'd1);
        check("r6_wrap_ack",    32'(ack),        32'h2);
        check("r6_wrap_data",   32'(data_out),   32'h122);
        req = 4'b0000;
        drain();

        // Crossing: every strobe reaches the slow side.
        for (int i = 0; i < 20; i++) tick();
        check("xing_tx", 32'(n_tx), 32'd14);
        check("xing_rx", 32'(n_rx), 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/strobe_arbiter.md
Name: strobe_arbiter

Overview:
Shares one strobe clock-crossing channel between NREQ requesters in the clk domain. Performs round-robin selection and issues one-cycle strobes with registered data. Enforces a minimum spacing of GAP clk cycles between strobes, so the destination-side toggle synchroniser never misses an edge. Sits directly upstream of the strobe crossing: strobe_out drives its strobe input and data_out drives its data input.

Parameters:
NREQ, 4, number of requesters; must be >= 2.
WIDTH, 8, payload width per requester.
GAP, 4, minimum clk cycles between consecutive strobe_out pulses; must be >= 2 (elaboration-time check). Set it to cover the destination sync depth plus the clock ratio.
IDW, clog2(NREQ), derived localparam: width of the source-index field.

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  synchronous, active-low reset
enable  in  1  when low, no new arbitration; an in-flight issue/holdoff still completes
req  in  NREQ  per-requester request level; held high with stable data until ack
req_data  in  NREQ*WIDTH  payload for requester i in bits [i*WIDTH +: WIDTH]
ack  out  NREQ  one-hot, one-cycle pulse to the granted requester
strobe_out  out  1  one-cycle pulse to the crossing
data_out  out  IDW+WIDTH  {src index, payload}, registered, held until next issue
busy  out  1  high during the ISSUE and HOLD states

Behaviour:
- All outputs registered. Reset values (reset_n low at a clk edge): strobe_out=0, ack=0, data_out=0, busy=0, state=IDLE, last_grant=NREQ-1, hold counter=0.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE: if enable and |req, then:
  - winner = first set req bit searching from (last_grant+1) mod NREQ upward, wrapping.
  - At that edge: data_out <= {winner, req_data[winner]}, last_grant <= winner, state <= ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): strobe_out=1, ack[winner]=1, busy=1.
  - Next state is HOLD with counter = GAP-2 if GAP > 2; otherwise IDLE.
- HOLD: busy=1; counter decrements each cycle; at 0, go to IDLE.
- Timing:
  - Latency: req sampled high in IDLE at cycle N gives strobe_out and ack in cycle N+1.
  - Strobe spacing: strobe at cycle t means the next strobe is no earlier than t+GAP; with continuous requests it is exactly t+GAP.
- Handshake rules:
  - Grant is committed at the arbitration edge. Later withdrawal of req (a protocol violation) still produces strobe/ack with the captured data.
  - A requester must drop req in the cycle after ack. If req is still high in the next IDLE evaluation, it is treated as a new request.
  - ack is never asserted without strobe_out in the same cycle, and vice versa.
  - data_out changes only at arbitration edges; it is stable for the whole strobe cycle and through HOLD.
- enable:
  - Sampled only in IDLE.
  - Deasserting it during ISSUE/HOLD does not cancel or shorten the sequence.
- Simultaneous requests: strictly round-robin. Each active requester is served at most once per NREQ grants while others are pending.
- Reset mid-operation:
  - In ISSUE: outputs are 0 from the reset edge on, so the in-progress strobe/ack pulse is truncated. Requesters observe no ack and keep requesting.
  - In HOLD: the holdoff is abandoned, but the first post-reset grant cannot occur before 2 cycles after release. The destination crossing tolerates this because reset is a system-wide event.
- Pointer wrap: last_grant=NREQ-1 searches from 0. After reset, requester 0 has highest priority.

Decomposition:
- Shared include/package: state encoding localparams (IDLE/ISSUE/HOLD), clog2 constant function, GAP>=2 / NREQ>=2 checks.
- One sub-module: rr_pick (combinational round-robin picker).
  - Inputs: req[NREQ], last[IDW].
  - Outputs: valid, idx[IDW].
  - It is reused by later multi-channel schedulers.
- Hold counter and FSM remain in strobe_arbiter.

Test Plan:
(All scenarios use NREQ=4, WIDTH=8, GAP=4.)
1. reset_n low 3 cycles with req=4'b1111 -> strobe_out=0, ack=0, data_out=0 throughout. First strobe 2 cycles after release has ack=4'b0001.
2. Only req[2] high with payload 8'hA5, seen in IDLE at cycle 10 -> cycle 11 strobe_out=1, ack=4'b0100, data_out={2'd2,8'hA5}. busy high cycles 11-13, low at 14.
3. req=4'b1111 held continuously (each re-raised after ack) -> grant order 0,1,2,3,0,... with strobes exactly 4 cycles apart and never closer.
4. req[0] and req[3] continuous -> alternating acks 0,3,0,3. Payload in data_out always matches the granted index.
5. enable=0 with req[1] pending for 20 cycles -> no strobe. enable=1 at cycle K -> strobe/ack[1] at K+1. enable dropped during HOLD -> HOLD still completes.
6. reset_n asserted during HOLD with req[3] pending -> outputs 0 next cycle, last_grant=3. After release, first grant goes to lowest pending index with wrap from 0. Also check an end-to-end strobe crossing at a 3:1 slower clk_out loses no strobes.
